// File: rtl/au_cmp_eq.sv
// au_cmp_eq: registered WIDTH-bit prefix-equality comparator, eq[i] = (a[i:0] == b[i:0]).
// Define AU_CMP_EQ_INREG_EN to add an input register stage (latency 2 instead of 1).
module au_cmp_eq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_vld,
    output logic [WIDTH-1:0] eq
);

    logic             stg_vld;
    logic [WIDTH-1:0] stg_a;
    logic [WIDTH-1:0] stg_b;

`ifdef AU_CMP_EQ_INREG_EN
    logic             in_vld_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Optional operand register; reset drops any pair captured here.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            in_vld_q <= in_vld;
            a_q      <= a;
            b_q      <= b;
        end
    end

    assign stg_vld = in_vld_q;
    assign stg_a   = a_q;
    assign stg_b   = b_q;
`else
    assign stg_vld = in_vld;
    assign stg_a   = a;
    assign stg_b   = b;
`endif

    logic [WIDTH-1:0] eq_d;

    // Kogge-Stone prefix AND over the per-bit XNOR vector; low s bits pass through at each level.
    always_comb begin
        eq_d = ~(stg_a ^ stg_b);
        for (int unsigned s = 1; s < WIDTH; s = s << 1) begin
            eq_d = eq_d & ((eq_d << s) | ~({WIDTH{1'b1}} << s));
        end
    end

    logic             out_vld_q;
    logic [WIDTH-1:0] eq_q;

    // Result register; eq holds across invalid cycles and is qualified by out_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            eq_q      <= '0;
        end else begin
            out_vld_q <= stg_vld;
            if (stg_vld) begin
                eq_q <= eq_d;
            end
        end
    end

    assign out_vld = out_vld_q;
    assign eq      = eq_q;

endmodule

// File: tb/tb_au_cmp_eq.sv
// tb_au_cmp_eq: randomized + directed bench for au_cmp_eq at WIDTH=8 and WIDTH=32.
// Honours AU_CMP_EQ_INREG_EN (latency 2) when defined.
module tb_au_cmp_eq;

`ifdef AU_CMP_EQ_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [7:0]  a8  = '0;
    logic [7:0]  b8  = '0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        ov8;
    logic        ov32;
    logic [7:0]  eq8;
    logic [31:0] eq32;

    au_cmp_eq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_vld(vld), .a(a8), .b(b8), .out_vld(ov8), .eq(eq8)
    );

    au_cmp_eq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_vld(vld), .a(a32), .b(b32), .out_vld(ov32), .eq(eq32)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Previous-cycle inputs and the value eq is expected to hold.
    logic        p_rst = 1'b1;
    logic        p_vld = 1'b0;
    logic [31:0] p_a   = '0;
    logic [31:0] p_b   = '0;
    logic [7:0]  x_eq8  = '0;
    logic [31:0] x_eq32 = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // eq = (lowest set bit of a^b) - 1, or all ones when the operands match.
    function automatic logic [63:0] prefix_eq(input logic [63:0] x, input int w);
        logic [63:0] m;
        logic [63:0] y;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        y = x & m;
        if (y == 64'd0) return m;
        return (y & (~y + 64'd1)) - 64'd1;
    endfunction

    // Drive one cycle, advance the reference, and compare both DUTs after the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
        logic        s_rst;
        logic        s_vld;
        logic [31:0] s_a;
        logic [31:0] s_b;
        rst = r; vld = v; a8 = a[7:0]; b8 = b[7:0]; a32 = a; b32 = b;
        @(posedge clk);
        #1;
        if (LAT == 1) begin
            s_rst = r;         s_vld = v;     s_a = a;   s_b = b;
        end else begin
            s_rst = r | p_rst; s_vld = p_vld; s_a = p_a; s_b = p_b;
        end
        p_rst = r; p_vld = v; p_a = a; p_b = b;
        if (r) begin
            x_eq8  = '0;
            x_eq32 = '0;
        end else if (!s_rst && s_vld) begin
            x_eq8  = 8'(prefix_eq(64'(s_a[7:0] ^ s_b[7:0]), 8));
            x_eq32 = 32'(prefix_eq(64'(s_a ^ s_b), 32));
        end
        check_eq("out_vld8",  64'(ov8),  64'(!s_rst && s_vld));
        check_eq("eq8",       64'(eq8),  64'(x_eq8));
        check_eq("out_vld32", 64'(ov32), 64'(!s_rst && s_vld));
        check_eq("eq32",      64'(eq32), 64'(x_eq32));
    endtask

    // Apply one 8-bit pair, wait out the latency, and compare against a literal table value.
    task automatic directed8(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp);
        step(1'b0, 1'b1, {4{a}}, {4{b}});
        repeat (LAT - 1) step(1'b0, 1'b0, '0, '0);
        check_eq(tag, 64'(eq8), 64'(exp));
    endtask

    logic [7:0]  tbl_a   [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h80, 8'h01, 8'hAA};
    logic [7:0]  tbl_b   [8] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h1F, 8'h00, 8'h00, 8'h2A};
    logic [7:0]  tbl_exp [8] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h0F, 8'h7F, 8'h00, 8'h7F};

    initial begin
        logic [31:0] r;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset held with in_vld high; outputs stay cleared.
        repeat (3) step(1'b1, 1'b1, '0, '0);
        step(1'b0, 1'b1, '0, '0);
        repeat (LAT) step(1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 8; i++) begin
            directed8($sformatf("table%0d_%h_%h", i, tbl_a[i], tbl_b[i]), tbl_a[i], tbl_b[i], tbl_exp[i]);
        end

        // Exhaustive 8-bit pairs, back to back; upper bits of the wide DUT are random.
        for (int i = 0; i < 65536; i++) begin
            r  = $urandom();
            ra = {r[31:8], 8'(i >> 8)};
            r  = $urandom();
            rb = {r[31:8], 8'(i)};
            step(1'b0, 1'b1, ra, rb);
        end

        // Alternating valid gaps: eq must hold while out_vld is low.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'(i % 2 == 0), $urandom(), $urandom());
        end

        // Reset pulses mid-stream discard in-flight pairs.
        for (int k = 0; k < 4; k++) begin
            repeat (5) step(1'b0, 1'b1, $urandom(), $urandom());
            step(1'b1, 1'b1, $urandom(), $urandom());
            repeat (LAT + 1) step(1'b0, 1'b1, $urandom(), $urandom());
        end

        // Wide random with equal-pair injections.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom());
            if ($urandom_range(0, 3) == 0) rb = ra ^ (32'd1 << $urandom_range(0, 31));
            step(1'b0, 1'($urandom_range(0, 7) != 0), ra, rb);
        end

        // Equal wide pairs must report full-word equality.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom();
            step(1'b0, 1'b1, ra, ra);
            repeat (LAT - 1) step(1'b0, 1'b0, '0, '0);
            check_eq("eq32_equal_pair", 64'(eq32), 64'(32'hFFFF_FFFF));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
